intr_serv_master: RTL and testbench
===================================

Name: intr_serv_master

Overview:
- Processor-side counterpart of the interrupt controller.
- Acts as bus initiator on the controller register port (wr_rd/enable/addr/wdata/rdata/ready/error). After a start pulse it programs one priority register per peripheral, then reads every register back and compares it with the written value.
- Once configured, it consumes intr_valid/intr_to_serv, emulates a fixed service time, and returns a one-cycle intr_service completion pulse.

Parameters:
- PERIPHERALS, 16, number of interrupt sources / priority registers
- ADDR_W, $clog2(PERIPHERALS), register address width
- DATA_W, $clog2(PERIPHERALS), register data (priority) width
- IDX_W, $clog2(PERIPHERALS), interrupt index width
- SERVICE_CYCLES, 4, cycles between accept and intr_service pulse (>=1)
- TIMEOUT, 15, max wait cycles for ready per transfer

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse; begin configuration (ignored unless cfg FSM in IDLE, DONE or ERR)
- cfg_prio  in  PERIPHERALS*DATA_W  priority table; slice i goes to register i; sampled at cfg_start
- wr_rd  out  1  1=write, 0=read
- enable  out  1  transfer request
- addr  out  ADDR_W  register address
- wdata  out  DATA_W  write data
- rdata  in  DATA_W  read data, valid with ready on a read
- ready  in  1  transfer complete this cycle
- error  in  1  slave error, valid with ready
- cfg_done  out  1  level; configuration and readback passed
- cfg_err  out  1  level; error, timeout or readback mismatch
- err_addr  out  ADDR_W  address of first failure
- intr_valid  in  1  controller presents an interrupt
- intr_to_serv  in  IDX_W  index of the presented interrupt
- intr_service  out  1  one-cycle completion pulse
- serv_busy  out  1  interrupt accepted, not yet completed
- last_idx  out  IDX_W  index of the most recently accepted interrupt
- serv_count  out  16  completed-service counter, wraps 0xFFFF->0

Behaviour:
- Reset (rst=0, async): all outputs 0; both FSMs in IDLE; counters 0.
- Bus handshake:
  - Initiator drives enable=1 with wr_rd/addr/wdata registered and holds them stable until the cycle ready=1.
  - Transfer completes in that ready cycle; error is sampled in the same cycle.
  - enable drops the cycle after completion. No back-to-back transfer: at least one enable=0 cycle between transfers.
- Config FSM states: C_IDLE, C_WR, C_GAP_W, C_RD, C_GAP_R, C_DONE, C_ERR.
  - cfg_start: latch cfg_prio, index=0, clear cfg_done/cfg_err, go to C_WR.
  - C_WR: enable=1, wr_rd=1, addr=index, wdata=prio[index].
  - Write ready with error=0 -> C_GAP_W. Then index++ -> C_WR; after the last index, index=0 -> C_RD.
  - C_RD: enable=1, wr_rd=0.
  - Read ready: if error=1 or rdata!=prio[index] -> C_ERR. Otherwise C_GAP_R, then next index, or C_DONE after the last.
  - ready with error=1 in any transfer -> C_ERR, err_addr=addr.
  - Wait counter reloads at each enable rise. If ready is still 0 after TIMEOUT cycles of enable=1 -> C_ERR, enable drops.
  - C_DONE: cfg_done=1. C_ERR: cfg_err=1. Both hold until the next cfg_start.
  - Minimum config time with ready in the first enable cycle: 2*PERIPHERALS*2 cycles (64 for defaults).
- Service FSM states: S_IDLE, S_SERVE, S_ACK, S_DROP.
  - Active only while cfg_done=1; otherwise intr_valid is ignored.
  - S_IDLE: if intr_valid=1, latch last_idx=intr_to_serv, serv_busy=1, timer=SERVICE_CYCLES-1 -> S_SERVE.
  - S_SERVE: decrement timer; at 0 -> S_ACK.
  - S_ACK: intr_service=1 for exactly one cycle, serv_count++, serv_busy=0 -> S_DROP.
  - S_DROP: wait for intr_valid=0 (controller deasserts after service), then S_IDLE. This prevents re-accepting the same request.
  - Accept-to-pulse latency = SERVICE_CYCLES+1 clocks.
  - intr_to_serv changing during S_SERVE is ignored.
- Simultaneous events:
  - cfg_start arriving while the service FSM is non-idle: the service FSM finishes the current interrupt (pulse still issued), then idles until cfg_done.
  - cfg_start during an active transfer: ignored.
- Reset mid-transfer: enable drops immediately (async); no partial state is retained.

Decomposition:
- Package intr_serv_pkg holds:
  - cfg_state_e and serv_state_e enums
  - default PERIPHERALS/width constants, shared with the controller define set
  - function prio_slice(table, idx)
- Natural sub-module: intr_bus_xfer, a single-transfer engine. It takes a request plus wr_rd/addr/wdata, and returns done, error, timeout and rdata, with the TIMEOUT counter inside. The config FSM in the top level sequences it.

Test Plan:
- cfg_prio = i for reg i, slave ready in 1st enable cycle, no error -> 16 writes then 16 reads, addr 0..15, cfg_done=1 at cycle 64, cfg_err=0.
- Slave returns rdata=0x3 for read addr 5 (expected 5) -> cfg_err=1, err_addr=5, cfg_done=0, no further transfers.
- Slave never asserts ready on write addr 2 -> enable high for exactly 15 cycles, then cfg_err=1, err_addr=2.
- After cfg_done: intr_valid=1, intr_to_serv=9, held until intr_service -> last_idx=9, serv_busy for 4 cycles, intr_service pulse at accept+5, serv_count=1. Keeping intr_valid high for 3 more cycles gives no second accept.
- intr_valid=1 before cfg_done -> no accept, intr_service stays 0, serv_count=0.
- rst asserted while enable=1 during write addr 7 -> enable, cfg_done, cfg_err, serv_count go 0 immediately. A new cfg_start after release restarts at addr 0.

Source files
------------

// File: rtl/intr_serv_pkg.sv
// Shared types, default geometry and helpers for the interrupt service master.
package intr_serv_pkg;

    // Default geometry, shared with the interrupt controller define set.
    localparam int PERIPHERALS_DEF    = 16;
    localparam int ADDR_W_DEF         = $clog2(PERIPHERALS_DEF);
    localparam int DATA_W_DEF         = $clog2(PERIPHERALS_DEF);
    localparam int IDX_W_DEF          = $clog2(PERIPHERALS_DEF);
    localparam int SERVICE_CYCLES_DEF = 4;
    localparam int TIMEOUT_DEF        = 15;

    // Configuration sequencer: write every register, then read every one back.
    typedef enum logic [2:0] {
        C_IDLE  = 3'd0,
        C_WR    = 3'd1,
        C_GAP_W = 3'd2,
        C_RD    = 3'd3,
        C_GAP_R = 3'd4,
        C_DONE  = 3'd5,
        C_ERR   = 3'd6
    } cfg_state_e;

    // Interrupt service emulation.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_ACK   = 2'd2,
        S_DROP  = 2'd3
    } serv_state_e;

    // Priority of register idx from a packed table (slice i belongs to register i).
    function automatic logic [DATA_W_DEF-1:0] prio_slice(
        input logic [PERIPHERALS_DEF*DATA_W_DEF-1:0] prio_tab,
        input logic [ADDR_W_DEF-1:0]                 idx
    );
        return prio_tab[int'(idx)*DATA_W_DEF +: DATA_W_DEF];
    endfunction

endpackage

// File: rtl/intr_bus_xfer.sv
// Single-transfer engine for the controller register port: raises enable with
// registered command fields, holds them until ready, and gives up after TIMEOUT
// enable cycles without ready.
module intr_bus_xfer #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_wr_rd,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_ready,
    input  logic              i_error,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_enable,
    output logic              o_wr_rd,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_done,
    output logic              o_error,
    output logic              o_timeout,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic              r_enable;
    logic              r_wr_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_wait;
    logic              w_last_wait;

    // The wait counter sits on its last value in the final enable cycle allowed.
    assign w_last_wait = (r_wait == CNT_W'(TIMEOUT - 1));

    assign o_enable  = r_enable;
    assign o_wr_rd   = r_wr_rd;
    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;
    assign o_done    = r_enable & i_ready;
    assign o_error   = r_enable & i_ready & i_error;
    assign o_timeout = r_enable & ~i_ready & w_last_wait;
    assign o_rdata   = i_rdata;

    // Launch a transfer, hold it until ready or timeout, then drop enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_enable <= 1'b0;
            r_wr_rd  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wait   <= '0;
        end else if (r_enable) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            if (i_ready || w_last_wait) begin
                r_enable <= 1'b0;
            end else begin
                r_wait <= r_wait + 1'b1;
            end
        end else if (i_start) begin
            r_enable <= 1'b1;
            r_wr_rd  <= i_wr_rd;
            r_addr   <= i_addr;
            r_wdata  <= i_wdata;
            r_wait   <= '0;
        end
    end

endmodule

// File: rtl/intr_serv_master.sv
// Processor-side initiator: programs and verifies the controller priority
// registers, then services presented interrupts with a fixed service time.
module intr_serv_master
    import intr_serv_pkg::*;
#(
    parameter int PERIPHERALS    = PERIPHERALS_DEF,
    parameter int ADDR_W         = $clog2(PERIPHERALS),
    parameter int DATA_W         = $clog2(PERIPHERALS),
    parameter int IDX_W          = IDX_W_DEF,
    parameter int SERVICE_CYCLES = SERVICE_CYCLES_DEF,
    parameter int TIMEOUT        = TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_start,
    input  logic [PERIPHERALS*DATA_W-1:0] cfg_prio,
    output logic                          wr_rd,
    output logic                          enable,
    output logic [ADDR_W-1:0]             addr,
    output logic [DATA_W-1:0]             wdata,
    input  logic [DATA_W-1:0]             rdata,
    input  logic                          ready,
    input  logic                          error,
    output logic                          cfg_done,
    output logic                          cfg_err,
    output logic [ADDR_W-1:0]             err_addr,
    input  logic                          intr_valid,
    input  logic [IDX_W-1:0]              intr_to_serv,
    output logic                          intr_service,
    output logic                          serv_busy,
    output logic [IDX_W-1:0]              last_idx,
    output logic [15:0]                   serv_count
);

    localparam int TMR_W = $clog2(SERVICE_CYCLES + 1);

    cfg_state_e                    r_cstate, w_cstate_nx;
    logic [ADDR_W-1:0]             r_index, w_index_nx, w_next_idx;
    logic [PERIPHERALS*DATA_W-1:0] r_prio;
    logic [ADDR_W-1:0]             r_err_addr;
    logic                          w_last_idx, w_cfg_load, w_fail;

    logic                          w_xfer_start, w_xfer_wr;
    logic [ADDR_W-1:0]             w_xfer_addr;
    logic [DATA_W-1:0]             w_xfer_wdata;
    logic                          w_xfer_done, w_xfer_err, w_xfer_tmo;
    logic [DATA_W-1:0]             w_xfer_rdata;

    serv_state_e                   r_sstate;
    logic [TMR_W-1:0]              r_timer;
    logic [IDX_W-1:0]              r_last_idx;
    logic [15:0]                   r_serv_count;

    intr_bus_xfer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_xfer_start),
        .i_wr_rd   (w_xfer_wr),
        .i_addr    (w_xfer_addr),
        .i_wdata   (w_xfer_wdata),
        .i_ready   (ready),
        .i_error   (error),
        .i_rdata   (rdata),
        .o_enable  (enable),
        .o_wr_rd   (wr_rd),
        .o_addr    (addr),
        .o_wdata   (wdata),
        .o_done    (w_xfer_done),
        .o_error   (w_xfer_err),
        .o_timeout (w_xfer_tmo),
        .o_rdata   (w_xfer_rdata)
    );

    assign w_next_idx = r_index + 1'b1;
    assign w_last_idx = (r_index == ADDR_W'(PERIPHERALS - 1));

    // Sequence writes then readbacks; a transfer is launched in the same cycle
    // the FSM leaves a gap (or sees cfg_start), so each transfer plus its gap
    // costs two cycles when the slave answers at once.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        w_cstate_nx  = r_cstate;
        w_index_nx   = r_index;
        w_cfg_load   = 1'b0;
        w_fail       = 1'b0;
        w_xfer_start = 1'b0;
        w_xfer_wr    = 1'b1;
        w_xfer_addr  = w_next_idx;
        w_xfer_wdata = prio_slice(r_prio, w_next_idx);
        case (r_cstate)
            C_IDLE, C_DONE, C_ERR: begin
                if (cfg_start) begin
                    w_cstate_nx  = C_WR;
                    w_index_nx   = '0;
                    w_cfg_load   = 1'b1;
                    w_xfer_start = 1'b1;
                    w_xfer_addr  = '0;
                    w_xfer_wdata = prio_slice(cfg_prio, '0);
                end
            end
            C_WR: begin
                if (w_xfer_tmo || w_xfer_err) begin
                    w_cstate_nx = C_ERR;
                    w_fail      = 1'b1;
                end else if (w_xfer_done) begin
                    w_cstate_nx = C_GAP_W;
                end
            end
            C_GAP_W: begin
                w_xfer_start = 1'b1;
                if (w_last_idx) begin
                    w_cstate_nx = C_RD;
                    w_index_nx  = '0;
                    w_xfer_wr   = 1'b0;
                    w_xfer_addr = '0;
                end else begin
                    w_cstate_nx = C_WR;
                    w_index_nx  = w_next_idx;
                end
            end
            C_RD: begin
                if (w_xfer_tmo || w_xfer_err ||
                    (w_xfer_done && (w_xfer_rdata != prio_slice(r_prio, r_index)))) begin
                    w_cstate_nx = C_ERR;
                    w_fail      = 1'b1;
                end else if (w_xfer_done) begin
                    w_cstate_nx = C_GAP_R;
                end
            end
            C_GAP_R: begin
                if (w_last_idx) begin
                    w_cstate_nx = C_DONE;
                end else begin
                    w_cstate_nx  = C_RD;
                    w_index_nx   = w_next_idx;
                    w_xfer_start = 1'b1;
                    w_xfer_wr    = 1'b0;
                end
            end
            default: w_cstate_nx = C_IDLE;
        endcase
    end

    // Config state, table snapshot and first-failure address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cstate   <= C_IDLE;
            r_index    <= '0;
            // NOTE: the table snapshot is reset too, so nothing survives a reset.
            r_prio     <= '0;
            r_err_addr <= '0;
        end else begin
            r_cstate <= w_cstate_nx;
            r_index  <= w_index_nx;
            if (w_cfg_load) begin
                r_prio     <= cfg_prio;
                r_err_addr <= '0;
            end
            if (w_fail) begin
                r_err_addr <= r_index;
            end
        end
    end

    assign cfg_done = (r_cstate == C_DONE);
    assign cfg_err  = (r_cstate == C_ERR);
    assign err_addr = r_err_addr;

    // Accept an interrupt only when configured; once accepted it always runs to
    // its completion pulse, then waits for the request to drop before re-arming.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sstate     <= S_IDLE;
            r_timer      <= '0;
            r_last_idx   <= '0;
            r_serv_count <= '0;
        end else begin
            case (r_sstate)
                S_IDLE: begin
                    if (cfg_done && intr_valid) begin
                        r_last_idx <= intr_to_serv;
                        r_timer    <= TMR_W'(SERVICE_CYCLES - 1);
                        r_sstate   <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (r_timer == '0) begin
                        r_sstate <= S_ACK;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_ACK: begin
                    r_serv_count <= r_serv_count + 1'b1;
                    r_sstate     <= S_DROP;
                end
                S_DROP: begin
                    if (!intr_valid) begin
                        r_sstate <= S_IDLE;
                    end
                end
                default: r_sstate <= S_IDLE;
            endcase
        end
    end

    assign serv_busy    = (r_sstate == S_SERVE);
    assign intr_service = (r_sstate == S_ACK);
    assign last_idx     = r_last_idx;
    assign serv_count   = r_serv_count;

endmodule

// File: tb/tb_intr_serv_master.sv
// Self-checking bench: a behavioural register slave on the bus, a transaction
// list model for configuration, and an interrupt source for the service side.
module tb_intr_serv_master;

    localparam int P  = 16;
    localparam int AW = 4;
    localparam int DW = 4;
    localparam int IW = 4;
    localparam int SC = 4;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cfg_start = 1'b0;
    logic [P*DW-1:0] cfg_prio = '0;
    logic            wr_rd, enable;
    logic [AW-1:0]   addr, err_addr;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rdata = '0;
    logic            ready = 1'b0;
    logic            error = 1'b0;
    logic            cfg_done, cfg_err;
    logic            intr_valid = 1'b0;
    logic [IW-1:0]   intr_to_serv = '0;
    logic            intr_service, serv_busy;
    logic [IW-1:0]   last_idx;
    logic [15:0]     serv_count;

    always #5 clk = ~clk;

    intr_serv_master #(
        .PERIPHERALS    (P),
        .SERVICE_CYCLES (SC),
        .TIMEOUT        (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (cfg_start),
        .cfg_prio     (cfg_prio),
        .wr_rd        (wr_rd),
        .enable       (enable),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .ready        (ready),
        .error        (error),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .err_addr     (err_addr),
        .intr_valid   (intr_valid),
        .intr_to_serv (intr_to_serv),
        .intr_service (intr_service),
        .serv_busy    (serv_busy),
        .last_idx     (last_idx),
        .serv_count   (serv_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scenario knobs: 0 none, 1 bad read data, 2 write error, 3 read error, 4 write hang.
    int unsigned   slave_wmax = 0;
    int            sc_kind = 0;
    int            sc_idx = 0;
    logic [DW-1:0] sc_bad = '0;

    logic [DW-1:0]    tab [P];
    logic [DW-1:0]    regs [P];
    logic [AW+DW:0]   txn_q [$];
    logic [AW+DW:0]   exp_q [$];
    bit               exp_err;
    int               exp_eaddr;
    int               exp_count = 0;

    bit            in_xfer = 0;
    bit            prev_ready = 0;
    bit            hang;
    int            wait_cnt, cur_wait;
    int            en_len = 0;
    int            proto_err = 0;
    logic [AW+DW:0] cap_cmd;

    // Register slave: answers after a random wait, records completed transfers
    // and flags unstable command fields or back-to-back enables.
    always @(negedge clk) begin
        if (enable && prev_ready) proto_err++;
        prev_ready = 0;
        if (!enable) begin
            ready   = 1'b0;
            error   = 1'b0;
            in_xfer = 0;
        end else begin
            if (!in_xfer) begin
                in_xfer  = 1;
                cur_wait = $urandom_range(slave_wmax);
                wait_cnt = 0;
                en_len   = 0;
                cap_cmd  = {wr_rd, addr, wdata};
            end else if ({wr_rd, addr, wdata} != cap_cmd) begin
                proto_err++;
            end
            en_len++;
            hang = (sc_kind == 4) && wr_rd && (int'(addr) == sc_idx);
            if (!hang && wait_cnt == cur_wait) begin
                ready = 1'b1;
                error = ((sc_kind == 2 && wr_rd) || (sc_kind == 3 && !wr_rd)) && (int'(addr) == sc_idx);
                if (wr_rd) begin
                    regs[addr] = wdata;
                    txn_q.push_back({1'b1, addr, wdata});
                end else begin
                    rdata = (sc_kind == 1 && int'(addr) == sc_idx) ? (regs[addr] ^ sc_bad) : regs[addr];
                    txn_q.push_back({1'b0, addr, {DW{1'b0}}});
                end
                prev_ready = 1;
            end else begin
                ready = 1'b0;
                error = 1'b0;
                wait_cnt++;
            end
        end
    end

    // Expected transfer list and outcome of one configuration run.
    task automatic model_cfg();
        exp_q.delete();
        exp_err   = 0;
        exp_eaddr = 0;
        for (int i = 0; i < P && !exp_err; i++) begin
            if (sc_kind == 4 && i == sc_idx) begin
                exp_err = 1; exp_eaddr = i;
            end else begin
                exp_q.push_back({1'b1, AW'(i), tab[i]});
                if (sc_kind == 2 && i == sc_idx) begin exp_err = 1; exp_eaddr = i; end
            end
        end
        for (int i = 0; i < P && !exp_err; i++) begin
            exp_q.push_back({1'b0, AW'(i), {DW{1'b0}}});
            if ((sc_kind == 1 || sc_kind == 3) && i == sc_idx) begin exp_err = 1; exp_eaddr = i; end
        end
    endtask

    task automatic prep_cfg();
        for (int i = 0; i < P; i++) cfg_prio[i*DW +: DW] = tab[i];
        txn_q.delete();
        proto_err = 0;
        model_cfg();
    endtask

    task automatic start_cfg();
        prep_cfg();
        @(negedge clk);
        cfg_start = 1'b1;
        @(posedge clk);
        #1 cfg_start = 1'b0;
    endtask

    task automatic wait_cfg(output int cycles);
        cycles = 0;
        while (!(cfg_done || cfg_err) && cycles < 3000) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("cfg_finished", cfg_done | cfg_err, 1);
    endtask

    task automatic check_cfg(input string tag);
        int mism;
        repeat (20) @(posedge clk);
        #1;
        check({tag, "_done"}, cfg_done, !exp_err);
        check({tag, "_err"}, cfg_err, exp_err);
        if (exp_err) check({tag, "_err_addr"}, err_addr, exp_eaddr);
        check({tag, "_ntxn"}, txn_q.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < txn_q.size() && i < exp_q.size(); i++)
            if (txn_q[i] !== exp_q[i]) mism++;
        check({tag, "_txn_list"}, mism, 0);
        check({tag, "_protocol"}, proto_err, 0);
    endtask

    task automatic identity_table();
        for (int i = 0; i < P; i++) tab[i] = DW'(i);
        sc_kind    = 0;
        slave_wmax = 0;
    endtask

    // One interrupt: present idx, change the index mid-service, optionally
    // restart configuration mid-service, hold the request after completion.
    task automatic serve_one(input logic [IW-1:0] idx, input int hold, input bit pulse_cfg);
        int k, busy_n, reacc;
        bit seen;
        @(posedge clk);
        #1 intr_valid = 1'b1;
        intr_to_serv = idx;
        k = 0; busy_n = 0; seen = 0; reacc = 0;
        while (!seen && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (k == 2) begin
                intr_to_serv = idx + 4'd5;
                if (pulse_cfg) cfg_start = 1'b1;
            end
            if (k == 3) cfg_start = 1'b0;
            if (serv_busy) busy_n++;
            if (intr_service) seen = 1;
        end
        check("serv_pulse_seen", seen, 1);
        check("serv_latency", k, SC + 1);
        check("serv_busy_cycles", busy_n, SC);
        check("serv_last_idx", last_idx, idx);
        exp_count++;
        repeat (hold) begin
            @(posedge clk); #1;
            if (serv_busy || intr_service) reacc++;
        end
        check("serv_count", serv_count, exp_count);
        intr_valid = 1'b0;
        @(posedge clk); #1;
        check("serv_no_reaccept", reacc, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n, busy_pre, found;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_bus", {enable, wr_rd, addr, wdata}, 0);
        check("rst_cfg", {cfg_done, cfg_err, err_addr}, 0);
        check("rst_serv", {intr_service, serv_busy, last_idx, serv_count}, 0);
        rst = 1'b1;

        // Interrupt before configuration is ignored.
        intr_valid = 1'b1; intr_to_serv = 4'd9;
        busy_pre = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (serv_busy || intr_service) busy_pre++;
        end
        intr_valid = 1'b0;
        check("pre_cfg_no_accept", busy_pre, 0);
        check("pre_cfg_serv_count", serv_count, 0);

        // Identity table, immediate ready: 64 cycles to done.
        identity_table();
        start_cfg();
        wait_cfg(cyc);
        check("ident_cycles", cyc, 4 * P);
        check_cfg("ident");

        // Service index 9 held three cycles after completion, then random ones.
        serve_one(4'd9, 3, 0);
        for (int t = 0; t < 6; t++) serve_one(IW'($urandom), $urandom_range(3, 1), 0);

        // cfg_start during service: interrupt still completes, config reruns.
        prep_cfg();
        serve_one(IW'($urandom), 2, 1);
        wait_cfg(cyc);
        check_cfg("cfg_during_serv");

        // Wrong readback at address 5.
        identity_table();
        sc_kind = 1; sc_idx = 5; sc_bad = 4'h6;
        start_cfg();
        wait_cfg(cyc);
        check_cfg("bad_rdata5");

        // Slave never answers the write to address 2.
        identity_table();
        sc_kind = 4; sc_idx = 2;
        start_cfg();
        wait_cfg(cyc);
        check("hang_enable_len", en_len, TO);
        check_cfg("hang_wr2");

        // Random tables, waits and faults.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < P; i++) tab[i] = DW'($urandom);
            slave_wmax = $urandom_range(3);
            sc_kind    = $urandom_range(4);
            sc_idx     = $urandom_range(P - 1);
            sc_bad     = DW'($urandom_range(15, 1));
            start_cfg();
            wait_cfg(cyc);
            check_cfg("rand");
        end

        // Reset while writing address 7, then a clean restart from address 0.
        check("pre_rst_serv_count", serv_count, exp_count);
        identity_table();
        start_cfg();
        n = 0;
        found = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (enable && wr_rd && addr == 4'd7) found = 1;
        end
        check("rst_found_wr7", found, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_enable", enable, 0);
        check("rst_mid_cfg", {cfg_done, cfg_err}, 0);
        check("rst_mid_serv_count", serv_count, 0);
        exp_count = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        start_cfg();
        wait_cfg(cyc);
        check("restart_cycles", cyc, 4 * P);
        check_cfg("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
